// File: rtl/mole_scheduler.sv
// mole_scheduler: sequences mole appearances for the whack-a-mole game.
// Owns the mole LEDs, picks holes from an external random source, times
// each up-window in 1 ms ticks and judges whacks as hit, miss or wrong hole.
// Difficulty rises every HITS_PER_LEVEL hits by shortening the up-window.
module mole_scheduler #(
    parameter int NUM_MOLES      = 30,
    parameter int UP_TIME_INIT   = 1000,
    parameter int UP_TIME_MIN    = 300,
    parameter int UP_TIME_STEP   = 100,
    parameter int GAP_TIME       = 250,
    parameter int FLASH_TIME     = 100,
    parameter int HITS_PER_LEVEL = 5
) (
    input  logic       clk,
    input  logic       reset_signal,
    input  logic       start,
    input  logic       abort,
    input  logic       tick,
    input  logic [3:0] rnd,
    input  logic [6:0] whack,
    output logic [6:0] mole_leds,
    output logic       hit,
    output logic       miss,
    output logic       wrong,
    output logic [3:0] level,
    output logic [5:0] moles_left,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {IDLE, GAP, PICK, UP, FLASH} state_t;

    localparam logic [15:0] GAP_LAST   = 16'(GAP_TIME - 1);
    localparam logic [15:0] FLASH_LAST = 16'(FLASH_TIME - 1);
    localparam logic [15:0] UP_INIT    = 16'(UP_TIME_INIT);
    localparam logic [15:0] UP_MIN     = 16'(UP_TIME_MIN);
    localparam logic [15:0] UP_STEP    = 16'(UP_TIME_STEP);
    localparam logic [16:0] UP_CLAMP   = 17'(UP_TIME_MIN + UP_TIME_STEP);
    localparam logic [7:0]  HITS_LAST  = 8'(HITS_PER_LEVEL - 1);
    localparam logic [5:0]  MOLES_INIT = 6'(NUM_MOLES);

    state_t      state, state_nxt;
    logic [15:0] timer, timer_nxt;
    logic [15:0] up_time, up_time_nxt;
    logic [2:0]  last_pos, last_pos_nxt;
    logic [7:0]  hit_cnt, hit_cnt_nxt;
    logic [3:0]  level_nxt;
    logic [5:0]  moles_left_nxt;
    logic [6:0]  leds_nxt;
    logic        hit_nxt, miss_nxt, wrong_nxt, done_nxt;

    logic [2:0]  rnd_pos;
    logic [2:0]  pick_pos;
    logic [6:0]  pos_mask;
    logic        is_hit, is_wrong, expire;
    logic [5:0]  moles_dec;

    // Shorten the up-window by one step; clamp first so it never underflows.
    function automatic logic [15:0] next_up_time(input logic [15:0] cur);
        if ({1'b0, cur} <= UP_CLAMP) return UP_MIN;
        return cur - UP_STEP;
    endfunction

    // Level counter saturates at 15.
    function automatic logic [3:0] sat_level_inc(input logic [3:0] cur);
        if (cur == 4'hF) return cur;
        return cur + 4'd1;
    endfunction

    // Hole selection and whack classification against the current mole.
    assign rnd_pos   = 3'(rnd % 4'd7);
    assign pick_pos  = (rnd_pos != last_pos) ? rnd_pos :
                       (rnd_pos == 3'd6)     ? 3'd0 : rnd_pos + 3'd1;
    assign pos_mask  = 7'b1 << last_pos;
    assign is_hit    = |(whack & pos_mask);
    assign is_wrong  = |(whack & ~pos_mask);
    assign expire    = tick && (timer == up_time - 16'd1);
    assign moles_dec = moles_left - 6'd1;
    assign busy      = (state != IDLE);

    // Next-state, counters and output pulses; abort overrides everything.
    always_comb begin
        state_nxt      = state;
        timer_nxt      = timer;
        up_time_nxt    = up_time;
        last_pos_nxt   = last_pos;
        hit_cnt_nxt    = hit_cnt;
        level_nxt      = level;
        moles_left_nxt = moles_left;
        hit_nxt        = 1'b0;
        miss_nxt       = 1'b0;
        wrong_nxt      = 1'b0;
        done_nxt       = 1'b0;
        leds_nxt       = 7'b0;

        if (abort && state != IDLE) begin
            state_nxt = IDLE;
            timer_nxt = 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_nxt      = GAP;
                        moles_left_nxt = MOLES_INIT;
                        level_nxt      = 4'd0;
                        up_time_nxt    = UP_INIT;
                        hit_cnt_nxt    = 8'd0;
                        last_pos_nxt   = 3'd7;
                        timer_nxt      = 16'd0;
                    end
                end
                GAP: begin
                    if (tick) begin
                        if (timer == GAP_LAST) begin
                            state_nxt = PICK;
                            timer_nxt = 16'd0;
                        end else begin
                            timer_nxt = timer + 16'd1;
                        end
                    end
                end
                PICK: begin
                    last_pos_nxt = pick_pos;
                    state_nxt    = UP;
                end
                UP: begin
                    if (is_hit) begin
                        hit_nxt        = 1'b1;
                        timer_nxt      = 16'd0;
                        moles_left_nxt = moles_dec;
                        if (hit_cnt == HITS_LAST) begin
                            hit_cnt_nxt = 8'd0;
                            level_nxt   = sat_level_inc(level);
                            up_time_nxt = next_up_time(up_time);
                        end else begin
                            hit_cnt_nxt = hit_cnt + 8'd1;
                        end
                        done_nxt  = (moles_dec == 6'd0);
                        state_nxt = (moles_dec == 6'd0) ? IDLE : FLASH;
                    end else if (expire) begin
                        miss_nxt       = 1'b1;
                        timer_nxt      = 16'd0;
                        moles_left_nxt = moles_dec;
                        done_nxt       = (moles_dec == 6'd0);
                        state_nxt      = (moles_dec == 6'd0) ? IDLE : GAP;
                    end else begin
                        wrong_nxt = is_wrong;
                        if (tick) timer_nxt = timer + 16'd1;
                    end
                end
                FLASH: begin
                    if (tick) begin
                        if (timer == FLASH_LAST) begin
                            state_nxt = GAP;
                            timer_nxt = 16'd0;
                        end else begin
                            timer_nxt = timer + 16'd1;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end

        if (state_nxt == UP)         leds_nxt = 7'b1 << last_pos_nxt;
        else if (state_nxt == FLASH) leds_nxt = 7'h7F;
    end

    // State register and registered outputs, cleared asynchronously.
    always_ff @(posedge clk or posedge reset_signal) begin
        if (reset_signal) begin
            state      <= IDLE;
            timer      <= 16'd0;
            up_time    <= UP_INIT;
            last_pos   <= 3'd7;
            hit_cnt    <= 8'd0;
            level      <= 4'd0;
            moles_left <= 6'd0;
            mole_leds  <= 7'd0;
            hit        <= 1'b0;
            miss       <= 1'b0;
            wrong      <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            timer      <= timer_nxt;
            up_time    <= up_time_nxt;
            last_pos   <= last_pos_nxt;
            hit_cnt    <= hit_cnt_nxt;
            level      <= level_nxt;
            moles_left <= moles_left_nxt;
            mole_leds  <= leds_nxt;
            hit        <= hit_nxt;
            miss       <= miss_nxt;
            wrong      <= wrong_nxt;
            done       <= done_nxt;
        end
    end

endmodule

// File: tb/tb_mole_scheduler.sv
// Directed bench for mole_scheduler: a short-round instance (a) covers
// misses, hits, flash, wrong holes, repeat avoidance, abort and reset;
// a long-window instance (b) covers level advancement and up-window clamping.
module tb_mole_scheduler;

    logic       clk = 1'b0;
    logic       reset_signal;
    logic       start, abort, tick;
    logic [3:0] rnd;
    logic [6:0] whack;

    logic [6:0] leds_a, leds_b;
    logic       hit_a, miss_a, wrong_a, busy_a, done_a;
    logic       hit_b, miss_b, wrong_b, busy_b, done_b;
    logic [3:0] level_a, level_b;
    logic [5:0] moles_left_a, moles_left_b;

    int n_checks = 0;
    int n_errors = 0;
    int ncyc = 0;
    int tper = 1;
    logic tick_at_edge;

    always #5 clk = ~clk;

    mole_scheduler #(
        .NUM_MOLES(3), .UP_TIME_INIT(4), .UP_TIME_MIN(2), .UP_TIME_STEP(1),
        .GAP_TIME(2), .FLASH_TIME(3), .HITS_PER_LEVEL(5)
    ) dut_a (
        .clk(clk), .reset_signal(reset_signal), .start(start), .abort(abort),
        .tick(tick), .rnd(rnd), .whack(whack), .mole_leds(leds_a),
        .hit(hit_a), .miss(miss_a), .wrong(wrong_a), .level(level_a),
        .moles_left(moles_left_a), .busy(busy_a), .done(done_a)
    );

    mole_scheduler #(
        .NUM_MOLES(12), .UP_TIME_INIT(1000), .UP_TIME_MIN(850), .UP_TIME_STEP(100),
        .GAP_TIME(2), .FLASH_TIME(3), .HITS_PER_LEVEL(5)
    ) dut_b (
        .clk(clk), .reset_signal(reset_signal), .start(start), .abort(abort),
        .tick(tick), .rnd(rnd), .whack(whack), .mole_leds(leds_b),
        .hit(hit_b), .miss(miss_b), .wrong(wrong_b), .level(level_b),
        .moles_left(moles_left_b), .busy(busy_b), .done(done_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: inputs seen at this edge are the ones set before the call;
    // outputs are sampled 1 ns after the edge, then pulses are cleared.
    task automatic cyc();
        @(posedge clk);
        tick_at_edge = tick;
        #1;
        ncyc++;
        start = 1'b0;
        abort = 1'b0;
        whack = 7'b0;
        tick  = (tper <= 1) ? 1'b1 : ((ncyc % tper) == 0);
    endtask

    task automatic do_reset();
        reset_signal = 1'b1;
        start = 1'b0; abort = 1'b0; whack = 7'b0; tick = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_signal = 1'b0;
        ncyc = 0;
        tick = (tper <= 1) ? 1'b1 : 1'b1;
    endtask

    // Advance until a single mole LED is lit.
    task automatic wait_up(input bit sel, input string tag, output logic [6:0] leds);
        bit found = 1'b0;
        leds = 7'b0;
        for (int i = 0; i < 200; i++) begin
            cyc();
            leds = sel ? leds_b : leds_a;
            if (leds != 7'b0 && leds != 7'h7F) begin
                found = 1'b1;
                break;
            end
        end
        check({tag, "_up_seen"}, found, 1'b1);
    endtask

    // Count ticks taken at clock edges until the miss pulse appears.
    task automatic count_to_miss(input bit sel, input int budget, output int ticks, output bit found);
        ticks = 0;
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            cyc();
            if (tick_at_edge) ticks++;
            if (sel ? miss_b : miss_a) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        logic [6:0] lv;
        int t;
        bit f;

        rnd = 4'd0;

        // Reset values
        tper = 1;
        reset_signal = 1'b1;
        start = 1'b0; abort = 1'b0; whack = 7'b0; tick = 1'b0;
        #3;
        check("rst_a", {leds_a, hit_a, miss_a, wrong_a, level_a, moles_left_a, busy_a, done_a}, 0);
        check("rst_b", {leds_b, hit_b, miss_b, wrong_b, level_b, moles_left_b, busy_b, done_b}, 0);

        // Full-miss round, tick every second cycle
        tper = 2;
        do_reset();
        start = 1'b1;
        cyc();
        check("start_busy", busy_a, 1'b1);
        check("start_left", moles_left_a, 3);
        check("start_leds", leds_a, 0);
        for (int m = 0; m < 3; m++) begin
            wait_up(1'b0, "fm", lv);
            count_to_miss(1'b0, 50, t, f);
            check("fm_miss_seen", f, 1'b1);
            check("fm_miss_ticks", t, 4);
            check("fm_miss_leds", leds_a, 0);
            check("fm_left", moles_left_a, 2 - m);
            check("fm_done", done_a, (m == 2));
            check("fm_busy", busy_a, (m != 2));
        end
        cyc();
        check("fm_miss_width", miss_a, 1'b0);
        check("fm_done_width", done_a, 1'b0);

        // Hit and flash, tick every cycle, rnd=0 -> hole 0
        tper = 1;
        rnd = 4'd0;
        do_reset();
        start = 1'b1;
        cyc();
        wait_up(1'b0, "hf", lv);
        check("hf_pos", lv, 7'b0000001);
        cyc();
        cyc();
        whack = leds_a;
        cyc();
        check("hf_hit", hit_a, 1'b1);
        check("hf_flash_leds", leds_a, 7'h7F);
        check("hf_no_miss", miss_a, 1'b0);
        check("hf_left", moles_left_a, 2);
        cyc();
        check("hf_hit_width", hit_a, 1'b0);
        check("hf_flash1", leds_a, 7'h7F);
        cyc();
        check("hf_flash2", leds_a, 7'h7F);
        cyc();
        check("hf_flash_end", leds_a, 0);
        check("hf_busy_gap", busy_a, 1'b1);
        cyc();
        check("hf_gap1", leds_a, 0);
        cyc();
        check("hf_pick", leds_a, 0);
        cyc();
        check("hf_next_pos", leds_a, 7'b0000010);

        // Wrong hole, then hit coinciding with expiry; rnd=9 -> hole 2
        rnd = 4'd9;
        do_reset();
        start = 1'b1;
        cyc();
        wait_up(1'b0, "wr", lv);
        check("wr_pos", lv, 7'b0000100);
        whack = 7'b0000001;
        cyc();
        check("wr_wrong", wrong_a, 1'b1);
        check("wr_no_hit", hit_a, 1'b0);
        check("wr_leds_stay", leds_a, 7'b0000100);
        cyc();
        check("wr_wrong_width", wrong_a, 1'b0);
        cyc();
        check("wr_no_early_miss", miss_a, 1'b0);
        whack = 7'b0000100;
        cyc();
        check("sim_hit", hit_a, 1'b1);
        check("sim_no_miss", miss_a, 1'b0);
        check("sim_leds", leds_a, 7'h7F);
        wait_up(1'b0, "wr2", lv);
        check("wr2_pos", lv, 7'b0001000);
        whack = 7'b0001001;
        cyc();
        check("dual_hit", hit_a, 1'b1);
        check("dual_no_wrong", wrong_a, 1'b0);
        check("dual_left", moles_left_a, 1);

        // Repeat avoidance with rnd=3, then abort and restart
        rnd = 4'd3;
        do_reset();
        start = 1'b1;
        cyc();
        wait_up(1'b0, "rp", lv);
        check("rp_pos1", lv, 7'b0001000);
        count_to_miss(1'b0, 50, t, f);
        check("rp_miss_seen", f, 1'b1);
        wait_up(1'b0, "rp2", lv);
        check("rp_pos2", lv, 7'b0010000);
        check("rp_left", moles_left_a, 2);
        abort = 1'b1;
        whack = lv;
        cyc();
        check("ab_busy", busy_a, 1'b0);
        check("ab_leds", leds_a, 0);
        check("ab_pulses", {hit_a, miss_a, wrong_a, done_a}, 0);
        check("ab_left_hold", moles_left_a, 2);
        cyc();
        cyc();
        check("ab_stay_idle", busy_a, 1'b0);
        start = 1'b1;
        cyc();
        check("rs_busy", busy_a, 1'b1);
        check("rs_left", moles_left_a, 3);
        wait_up(1'b0, "rs", lv);
        whack = lv;
        cyc();
        check("rs_hit", hit_a, 1'b1);
        cyc();
        check("rs_flash", leds_a, 7'h7F);
        #2;
        reset_signal = 1'b1;
        #1;
        check("async_rst", {leds_a, hit_a, miss_a, wrong_a, level_a, moles_left_a, busy_a, done_a}, 0);
        @(posedge clk);
        #1;
        reset_signal = 1'b0;

        // Leveling on the long-window instance
        rnd = 4'd5;
        do_reset();
        start = 1'b1;
        cyc();
        for (int k = 1; k <= 10; k++) begin
            wait_up(1'b1, "lv", lv);
            whack = lv;
            cyc();
            check("lv_hit", hit_b, 1'b1);
            if (k == 4)  check("lv_level0", level_b, 0);
            if (k == 5)  check("lv_level1", level_b, 1);
            if (k == 10) check("lv_level2", level_b, 2);
        end
        wait_up(1'b1, "lv11", lv);
        count_to_miss(1'b1, 1200, t, f);
        check("lv11_miss_seen", f, 1'b1);
        check("lv11_ticks", t, 850);
        check("lv11_left", moles_left_b, 1);
        check("lv11_level", level_b, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mole_scheduler.md
# mole_scheduler

Sequences mole appearances for the whack-a-mole game: it owns the mole LEDs, picks holes from an external random source, times each mole's up-window, and judges whacks as hit, miss or wrong hole. It adds difficulty levels that shorten the up-window as hits accumulate. It sits between the 1 ms prescaler, the LFSR and switch-edge detector on one side and the score/display logic on the other.

## Interface
- NUM_MOLES, 30: moles presented per round.
- UP_TIME_INIT, 1000: initial up-window, in ticks.
- UP_TIME_MIN, 300: up-window floor, in ticks.
- UP_TIME_STEP, 100: up-window reduction per level, in ticks.
- GAP_TIME, 250: dark interval before each mole, in ticks.
- FLASH_TIME, 100: all-LED hit flash duration, in ticks.
- HITS_PER_LEVEL, 5: hits needed to advance one level.

Ports:
- clk  in  1  system clock (50 MHz).
- reset_signal  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a round when idle.
- abort  in  1  one-cycle pulse; ends the round immediately.
- tick  in  1  one-cycle pulse every 1 ms; the only time base.
- rnd  in  4  random value, sampled only in PICK.
- whack  in  7  one-cycle per-hole switch-toggle pulses.
- mole_leds  out  7  LED drive.
- hit  out  1  one-cycle pulse on a correct whack.
- miss  out  1  one-cycle pulse on up-window expiry.
- wrong  out  1  one-cycle pulse when a non-mole hole is whacked during UP.
- level  out  4  current level, 0..15.
- moles_left  out  6  moles remaining in the round.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at normal round completion.

## Operation
- Reset values: all outputs 0. Internal state: state=IDLE, up_time=UP_TIME_INIT, last_pos=7 (none), hit_cnt=0, timer=0.
- IDLE: mole_leds=0.
  - start -> GAP.
  - On entering GAP from IDLE: moles_left=NUM_MOLES, level=0, up_time=UP_TIME_INIT, hit_cnt=0, last_pos=7, timer=0.
- GAP: mole_leds=0. timer increments on each tick. When timer reaches GAP_TIME-1 and tick is high -> PICK, timer=0.
- PICK (1 cycle):
  - pos = rnd mod 7.
  - If pos == last_pos, pos = (pos+1) mod 7, so a hole never repeats back-to-back.
  - last_pos <= pos; -> UP.
- UP: mole_leds one-hot at pos. timer counts ticks.
  - whack[pos]: hit pulse, hit_cnt+1 -> FLASH.
  - Window expiry (timer == up_time-1 and tick): miss pulse -> GAP.
  - whack on any other bit: wrong pulse, mole stays up, timer unaffected.
  - Every exit from UP decrements moles_left.
- FLASH: mole_leds=7'h7F for FLASH_TIME ticks -> GAP.
- Round end: on an exit from UP that makes moles_left 0, the next state is IDLE instead of GAP or FLASH. done pulses the same cycle the state becomes IDLE. No flash is shown on the final mole.
- Level rule: when hit_cnt reaches HITS_PER_LEVEL:
  - hit_cnt=0.
  - level+1, saturating at 15.
  - up_time = max(UP_TIME_MIN, up_time-UP_TIME_STEP).
  - The new up_time applies from the next mole.
- Arithmetic: timer and up_time are 16-bit unsigned. The up_time subtraction must not underflow; clamp before subtracting.
- whack inputs outside UP are ignored with no pulse. start while busy is ignored.

## Timing
- start at cycle N -> busy=1 and state=GAP at N+1.
- Final GAP tick at cycle N -> PICK at N+1 -> mole_leds one-hot at N+2.
- whack[pos] at cycle N in UP -> hit=1 and mole_leds=7'h7F at N+1.
- Expiry tick at N -> miss=1 and mole_leds=0 at N+1.
- whack[pos] and the expiry tick in the same cycle: hit wins, no miss.
- Simultaneous whack[pos] and whack[other] in one cycle: hit only, no wrong.
- abort has priority over every other event.
  - Next cycle: IDLE, mole_leds=0, busy=0.
  - No done, hit or miss pulse.
  - level and moles_left hold their values.
- reset_signal mid-round: all outputs return to reset values immediately (asynchronously).
- Output pulses are registered, last exactly one cycle, and never assert together except hit with done, or miss with done.

## Test plan
- Full-miss round: NUM_MOLES=3, GAP_TIME=2, UP_TIME_INIT=4, no whacks -> 3 miss pulses, each 4 ticks after its LED rises; done at the last; moles_left 3->2->1->0; busy drops with done.
- Hit and flash: whack[pos] 2 ticks into UP -> hit=1 and mole_leds=7'h7F next cycle for FLASH_TIME ticks, then GAP with LEDs dark; no miss pulse.
- Leveling: 10 consecutive hits with HITS_PER_LEVEL=5, UP_TIME_INIT=1000, STEP=100, MIN=850 -> level 1 then 2; up_time 900 then 850 (clamped); the 11th mole times out after 850 ticks.
- Wrong hole and simultaneity: rnd=4'd9 gives pos=2.
  - whack=7'b0000001 -> wrong pulse, LED 2 stays lit.
  - Then whack[2] coinciding with the expiry tick -> hit only.
- Repeat avoidance: rnd=4'd3 for two consecutive moles -> positions 3 then 4.
- Abort/reset: abort during UP -> IDLE next cycle with LEDs 0 and no done. Restart with start. Assert reset_signal mid-FLASH -> all outputs 0 immediately.
